// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch block.
//   ADDR_W_DEF     : default instruction address width (32-entry memory)
//   START_ADDR_DEF : default first address issued after start
//   LAST_ADDR_DEF  : default final program address
//   CNT_W          : width of the accepted-address counter
//   fetch_state_e  : FSM encoding (IDLE=0, RUN=1, DONE=2)
package fetch_pkg;
  localparam int ADDR_W_DEF     = 5;
  localparam int START_ADDR_DEF = 0;
  localparam int LAST_ADDR_DEF  = 13;
  localparam int CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : system clock (rising edge)
//   rst   : asynchronous active-high reset, clears count
//   inc   : add one this cycle (ignored once count is all ones)
//   clr   : synchronous clear, wins over inc
//   count : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch address sequencer.
// Issues addresses START_ADDR..LAST_ADDR to a downstream consumer, honouring
// stall, backpressure and branch/jump redirects, then parks in DONE.
//   clk, rst         : clock, asynchronous active-high reset
//   start            : pulse that (re)starts fetching from START_ADDR
//   stall            : hazard hold, suppresses addr_valid
//   redirect_valid   : branch/jump taken; redirect_addr is the target
//   instAddr         : address offered downstream
//   addr_valid       : instAddr is valid this cycle
//   addr_ready       : downstream accepts instAddr
//   done             : program finished (state DONE)
//   err              : sticky out-of-range redirect flag
//   fetch_count      : accepted addresses, saturating at 255
//   fsm_state        : current FSM state, for observation
//
// Handshake: an address is transferred in a cycle where addr_valid and
// addr_ready are both 1. addr_valid never depends on addr_ready; while
// addr_valid=1 and addr_ready=0, instAddr is held stable (unless a redirect
// replaces it).
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int START_ADDR = START_ADDR_DEF,
  parameter int LAST_ADDR  = LAST_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] instAddr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  fetch_count,
  output fetch_state_e      fsm_state
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              err_nxt;
  logic              cnt_clr;
  logic              hs;

  assign addr_valid = (state == RUN) && !stall;
  assign hs         = addr_valid && addr_ready;
  assign done       = (state == DONE);
  assign fsm_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      instAddr <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      instAddr <= addr_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = instAddr;
    err_nxt   = err;
    cnt_clr   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          addr_nxt  = FIRST;
          err_nxt   = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      RUN: begin
        // A redirect overrides both the increment and stall; any handshake
        // in the same cycle is still counted by the counter below.
        if (redirect_valid) begin
          if (redirect_addr > LAST) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            addr_nxt = redirect_addr;
          end
        end else if (hs) begin
          if (instAddr == LAST) begin
            state_nxt = DONE;
          end else begin
            addr_nxt = instAddr + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_count (
    .clk  (clk),
    .rst  (rst),
    .inc  (hs),
    .clr  (cnt_clr),
    .count(fetch_count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  localparam int AW   = 5;
  localparam int LAST = 13;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] inst_addr;
  logic          addr_valid;
  logic          addr_ready;
  logic          done;
  logic          err;
  logic [7:0]    fetch_count;
  logic [1:0]    fsm_state;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0=idle, 1=running, 2=finished.
  int m_phase;
  int m_addr;
  int m_count;
  int m_err;

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .instAddr      (inst_addr),
    .addr_valid    (addr_valid),
    .addr_ready    (addr_ready),
    .done          (done),
    .err           (err),
    .fetch_count   (fetch_count),
    .fsm_state     (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_addr  = 0;
    m_count = 0;
    m_err   = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  int'(inst_addr), m_addr);
    check({tag, ".valid"}, int'(addr_valid), (m_phase == 1 && !stall) ? 1 : 0);
    check({tag, ".done"},  int'(done), (m_phase == 2) ? 1 : 0);
    check({tag, ".err"},   int'(err), m_err);
    check({tag, ".count"}, int'(fetch_count), m_count);
    check({tag, ".state"}, int'(fsm_state), m_phase);
  endtask

  // One clock cycle: drive at the falling edge, check, advance model, clock.
  task automatic cycle(input string tag, input bit st, input bit sl,
                       input bit rv, input int ra, input bit rdy);
    bit hs;
    start          = st;
    stall          = sl;
    redirect_valid = rv;
    redirect_addr  = AW'(ra);
    addr_ready     = rdy;
    #1;
    check_all(tag);
    if (m_phase != 1) begin
      if (st) begin
        m_phase = 1;
        m_addr  = 0;
        m_count = 0;
        m_err   = 0;
      end
    end else begin
      hs = !sl && rdy;
      if (hs) m_count = (m_count < 255) ? m_count + 1 : 255;
      if (rv) begin
        if (ra > LAST) begin
          m_err   = 1;
          m_phase = 2;
        end else begin
          m_addr = ra;
        end
      end else if (hs) begin
        if (m_addr == LAST) m_phase = 2;
        else m_addr = m_addr + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (m_addr != target && n < 40) begin
      cycle("run_to", 0, 0, 0, 0, 1);
      n++;
    end
    check("run_to.reached", m_addr == target ? int'(inst_addr) : -1, target);
  endtask

  initial begin
    int n;
    model_reset();
    rst = 1'b1;
    start = 0; stall = 0; redirect_valid = 0; redirect_addr = '0; addr_ready = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    @(negedge clk);

    // Idle: redirect ignored, stays idle without start.
    cycle("idle", 0, 0, 1, 3, 1);
    cycle("idle", 0, 0, 0, 0, 1);

    // Straight run 0..13, then done with 14 accepted.
    cycle("start", 1, 0, 0, 0, 1);
    n = 0;
    while (m_phase == 1 && n < 20) begin
      cycle("straight", 0, 0, 0, 0, 1);
      n++;
    end
    #1;
    check("straight.done", int'(done), 1);
    check("straight.count", int'(fetch_count), 14);
    check("straight.addr", int'(inst_addr), LAST);
    cycle("done_redirect_ignored", 0, 0, 1, 4, 1);

    // Restart from DONE.
    cycle("restart", 1, 0, 0, 0, 1);
    #1;
    check("restart.state", int'(fsm_state), 1);
    check("restart.count", int'(fetch_count), 0);

    // Backpressure at 4.
    run_to(4);
    for (int i = 0; i < 3; i++) cycle("bp", 0, 0, 0, 0, 0);
    cycle("bp_accept", 0, 0, 0, 0, 1);
    #1;
    check("bp.resume", int'(inst_addr), 5);

    // Stall at 7.
    run_to(7);
    for (int i = 0; i < 2; i++) cycle("stall", 0, 1, 0, 0, 1);
    cycle("stall_release", 0, 0, 0, 0, 1);

    // Redirect at 9 with handshake, then out-of-range redirect.
    run_to(9);
    cycle("redir", 0, 0, 1, 2, 1);
    #1;
    check("redir.addr", int'(inst_addr), 2);
    cycle("redir_next", 0, 0, 0, 0, 1);
    cycle("redir_bad", 0, 0, 1, 20, 0);
    #1;
    check("redir_bad.err", int'(err), 1);
    check("redir_bad.done", int'(done), 1);
    cycle("after_err", 0, 0, 0, 0, 1);

    // Mid-run asynchronous reset at 6.
    cycle("restart2", 1, 0, 0, 0, 1);
    run_to(6);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle("post_rst", 0, 0, 0, 0, 1);

    // Saturation: keep redirecting to 0 with every address accepted.
    cycle("sat_start", 1, 0, 0, 0, 1);
    for (int i = 0; i < 270; i++) cycle("sat", 0, 0, 1, 0, 1);
    #1;
    check("sat.count", int'(fetch_count), 255);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle("rand",
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0,
            ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(0, LAST),
            $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
